// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU control path: default bus and opcode widths,
// the opcode encoding seen in the IR, and the 4-bit sequencer state encoding
// that is also exported on state_dbg. The IR, the ALU and the benches import
// this package so that every block agrees on the same encodings.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int WORD_W_DEFAULT = 8;
  localparam int OP_W_DEFAULT   = 4;

  // Opcode encoding. Codes 11..14 are not named; they decode as NOP,
  // which is given the top code as its representative value.
  typedef enum logic [3:0] {
    OP_LOAD  = 4'd0,
    OP_STORE = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_XOR   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_BEQ   = 4'd7,
    OP_BNE   = 4'd8,
    OP_JMP   = 4'd9,
    OP_HALT  = 4'd10,
    OP_NOP   = 4'd15
  } opcode_t;

  // Sequencer states; this encoding is visible on state_dbg.
  typedef enum logic [3:0] {
    FETCH_ADDR = 4'd0,
    FETCH_MEM  = 4'd1,
    FETCH_IR   = 4'd2,
    DECODE     = 4'd3,
    OPER_MEM   = 4'd4,
    OPER_EXEC  = 4'd5,
    STORE_DATA = 4'd6,
    STORE_MEM  = 4'd7,
    STEP_WAIT  = 4'd8,
    HALT       = 4'd9
  } state_t;

endpackage

// File: rtl/edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Rising-edge detector: one history register and an AND gate. o_rise is high
// in the cycle where i_level is 1 and was 0 at the previous clock edge, so a
// level held high produces a single one-cycle pulse.
//
// Ports:
//   clock    in  1  rising-edge clock
//   n_reset  in  1  synchronous active-low reset, clears the history register
//   i_level  in  1  level to watch
//   o_rise   out 1  high while i_level is newly high
// ---------------------------------------------------------------------------
module edge_detect (
  input  logic clock,
  input  logic n_reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  // Remember the level seen at the last edge; reset forgets any pending edge
  // so a request raised during reset still counts once the block restarts.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
// Microsequencer for a small accumulator CPU. Walks the fetch / decode /
// operand / execute / store phases of each instruction and drives the datapath
// and ALU control strobes. Supports single-instruction stepping driven by
// step_req and a HALT state that only reset can leave.
//
// Ports:
//   clock, n_reset        clock and synchronous active-low reset
//   op[OP_W-1:0]          opcode from the IR
//   z_flag                ALU zero flag (conditional branches)
//   step_mode, step_req   stepping enable and step request
//   ACC_bus .. CS, R_NW   datapath and memory controls
//   ALU_*                 ALU operand/function selects
//   halted                high in HALT
//   state_dbg[3:0]        current state encoding
// ---------------------------------------------------------------------------
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEFAULT,
  parameter int OP_W   = OP_W_DEFAULT
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            step_mode,
  input  logic            step_req,
  output logic            ACC_bus,
  output logic            load_ACC,
  output logic            PC_bus,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            load_IR,
  output logic            load_MAR,
  output logic            MDR_bus,
  output logic            load_MDR,
  output logic            Addr_bus,
  output logic            CS,
  output logic            R_NW,
  output logic            ALU_ACC,
  output logic            ALU_add,
  output logic            ALU_sub,
  output logic            ALU_xor,
  output logic            ALU_and,
  output logic            ALU_or,
  output logic            halted,
  output logic [3:0]      state_dbg
);

  // Parameter sanity: the decode below needs at least four opcode bits.
  if (OP_W < 4) begin : gBadOpW
    $error("cpu_sequencer: OP_W must be at least 4");
  end
  if (WORD_W < 1) begin : gBadWordW
    $error("cpu_sequencer: WORD_W must be positive");
  end

  state_t     r_state;
  logic       w_stepRise;
  logic       w_opHigh;
  logic [3:0] w_opLow;
  logic       w_isLoadAlu;
  logic       w_isStore;
  logic       w_isHalt;
  logic       w_takeJump;
  state_t     w_endState;

  edge_detect uStepEdge (
    .clock   (clock),
    .n_reset (n_reset),
    .i_level (step_req),
    .o_rise  (w_stepRise)
  );

  // Opcodes wider than four bits: any set upper bit makes the code a NOP.
  if (OP_W > 4) begin : gOpHigh
    assign w_opHigh = |op[OP_W-1:4];
  end else begin : gOpNarrow
    assign w_opHigh = 1'b0;
  end

  assign w_opLow = op[3:0];

  // Opcode classes used by both the next-state logic and the DECODE strobes.
  // A jump is taken for JMP, BEQ with Z set, or BNE with Z clear.
  always_comb begin
    w_isLoadAlu = 1'b0;
    w_isStore   = 1'b0;
    w_isHalt    = 1'b0;
    w_takeJump  = 1'b0;
    if (!w_opHigh) begin
      case (w_opLow)
        OP_LOAD, OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR: w_isLoadAlu = 1'b1;
        OP_STORE: w_isStore  = 1'b1;
        OP_BEQ:   w_takeJump = z_flag;
        OP_BNE:   w_takeJump = ~z_flag;
        OP_JMP:   w_takeJump = 1'b1;
        OP_HALT:  w_isHalt   = 1'b1;
        default:  ;
      endcase
    end
  end

  // Where every instruction finishes: park in STEP_WAIT when stepping.
  assign w_endState = step_mode ? STEP_WAIT : FETCH_ADDR;

  // State register. Reset wins from any state, including STORE_MEM and HALT,
  // which aborts whatever instruction was in flight. STEP_WAIT leaves on a
  // fresh step_req edge; an edge seen in any other state is simply dropped
  // because the detector's history has already moved on by the time we wait.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_state <= FETCH_ADDR;
    end else begin
      case (r_state)
        FETCH_ADDR: r_state <= FETCH_MEM;
        FETCH_MEM:  r_state <= FETCH_IR;
        FETCH_IR:   r_state <= DECODE;
        DECODE: begin
          if (w_isHalt) begin
            r_state <= HALT;
          end else if (w_isLoadAlu) begin
            r_state <= OPER_MEM;
          end else if (w_isStore) begin
            r_state <= STORE_DATA;
          end else begin
            r_state <= w_endState;
          end
        end
        OPER_MEM:   r_state <= OPER_EXEC;
        OPER_EXEC:  r_state <= w_endState;
        STORE_DATA: r_state <= STORE_MEM;
        STORE_MEM:  r_state <= w_endState;
        STEP_WAIT: begin
          if (!step_mode || w_stepRise) begin
            r_state <= FETCH_ADDR;
          end
        end
        HALT:       r_state <= HALT;
        default:    r_state <= FETCH_ADDR;
      endcase
    end
  end

  // Control strobes, decoded from the current state (and op/z in DECODE).
  // Everything defaults low except R_NW, which idles in the read direction
  // so only STORE_MEM ever presents a write to memory. Each state drives at
  // most one of the four bus enables.
  always_comb begin
    ACC_bus  = 1'b0;
    load_ACC = 1'b0;
    PC_bus   = 1'b0;
    load_PC  = 1'b0;
    INC_PC   = 1'b0;
    load_IR  = 1'b0;
    load_MAR = 1'b0;
    MDR_bus  = 1'b0;
    load_MDR = 1'b0;
    Addr_bus = 1'b0;
    CS       = 1'b0;
    R_NW     = 1'b1;
    ALU_ACC  = 1'b0;
    ALU_add  = 1'b0;
    ALU_sub  = 1'b0;
    ALU_xor  = 1'b0;
    ALU_and  = 1'b0;
    ALU_or   = 1'b0;
    halted   = 1'b0;
    case (r_state)
      FETCH_ADDR: begin
        PC_bus   = 1'b1;
        load_MAR = 1'b1;
        INC_PC   = 1'b1;
        load_PC  = 1'b1;
      end
      FETCH_MEM: CS = 1'b1;
      FETCH_IR: begin
        MDR_bus = 1'b1;
        load_IR = 1'b1;
      end
      DECODE: begin
        if (w_isLoadAlu || w_isStore) begin
          Addr_bus = 1'b1;
          load_MAR = 1'b1;
        end else if (w_takeJump) begin
          Addr_bus = 1'b1;
          load_PC  = 1'b1;
        end
      end
      OPER_MEM: CS = 1'b1;
      OPER_EXEC: begin
        MDR_bus  = 1'b1;
        ALU_ACC  = 1'b1;
        load_ACC = 1'b1;
        if (!w_opHigh) begin
          case (w_opLow)
            OP_ADD:  ALU_add = 1'b1;
            OP_SUB:  ALU_sub = 1'b1;
            OP_XOR:  ALU_xor = 1'b1;
            OP_AND:  ALU_and = 1'b1;
            OP_OR:   ALU_or  = 1'b1;
            default: ;
          endcase
        end
      end
      STORE_DATA: begin
        ACC_bus  = 1'b1;
        load_MDR = 1'b1;
      end
      STORE_MEM: begin
        CS   = 1'b1;
        R_NW = 1'b0;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
// Self-checking bench for cpu_sequencer. A reference model works at the level
// of "which phases does this instruction visit" and "which strobes does each
// phase raise", and every cycle is compared against it. Directed scenarios
// cover stepping, halt and reset aborts; a random phase runs many opcodes.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic       clock = 1'b0;
  logic       n_reset;
  logic [3:0] op;
  logic       z_flag;
  logic       step_mode;
  logic       step_req;
  logic ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, load_MAR;
  logic MDR_bus, load_MDR, Addr_bus, CS, R_NW;
  logic ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_and, ALU_or, halted;
  logic [3:0] state_dbg;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct packed {
    logic accBus, loadAcc, pcBus, loadPc, incPc, loadIr, loadMar;
    logic mdrBus, loadMdr, addrBus, cs, rNw;
    logic aluAcc, aluAdd, aluSub, aluXor, aluAnd, aluOr, halt;
  } ctl_t;

  cpu_sequencer #(.WORD_W(8), .OP_W(4)) dut (
    .clock(clock), .n_reset(n_reset), .op(op), .z_flag(z_flag),
    .step_mode(step_mode), .step_req(step_req),
    .ACC_bus(ACC_bus), .load_ACC(load_ACC), .PC_bus(PC_bus), .load_PC(load_PC),
    .INC_PC(INC_PC), .load_IR(load_IR), .load_MAR(load_MAR), .MDR_bus(MDR_bus),
    .load_MDR(load_MDR), .Addr_bus(Addr_bus), .CS(CS), .R_NW(R_NW),
    .ALU_ACC(ALU_ACC), .ALU_add(ALU_add), .ALU_sub(ALU_sub), .ALU_xor(ALU_xor),
    .ALU_and(ALU_and), .ALU_or(ALU_or), .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // Hard stop in case something wedges the bench itself.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic ctl_t observedCtl();
    ctl_t c;
    c = '{ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, load_MAR,
          MDR_bus, load_MDR, Addr_bus, CS, R_NW,
          ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_and, ALU_or, halted};
    return c;
  endfunction

  // Opcode classes as the instruction set describes them.
  function automatic bit isMemAlu(input logic [3:0] o);
    return (o <= 4'd6) && (o != 4'd1);
  endfunction

  function automatic bit jumpTaken(input logic [3:0] o, input logic z);
    return (o == 4'd9) || (o == 4'd7 && z) || (o == 4'd8 && !z);
  endfunction

  // Which strobes a phase raises; everything else low, R_NW high.
  function automatic ctl_t expCtl(input state_t s, input logic [3:0] o, input logic z);
    ctl_t c;
    c = '0;
    c.rNw = 1'b1;
    case (s)
      FETCH_ADDR: begin c.pcBus = 1; c.loadMar = 1; c.incPc = 1; c.loadPc = 1; end
      FETCH_MEM:  c.cs = 1;
      FETCH_IR:   begin c.mdrBus = 1; c.loadIr = 1; end
      DECODE: begin
        if (o <= 4'd6)          begin c.addrBus = 1; c.loadMar = 1; end
        else if (jumpTaken(o, z)) begin c.addrBus = 1; c.loadPc = 1; end
      end
      OPER_MEM:   c.cs = 1;
      OPER_EXEC: begin
        c.mdrBus = 1; c.aluAcc = 1; c.loadAcc = 1;
        c.aluAdd = (o == 4'd2); c.aluSub = (o == 4'd3); c.aluXor = (o == 4'd4);
        c.aluAnd = (o == 4'd5); c.aluOr  = (o == 4'd6);
      end
      STORE_DATA: begin c.accBus = 1; c.loadMdr = 1; end
      STORE_MEM:  begin c.cs = 1; c.rNw = 0; end
      HALT:       c.halt = 1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic checkCycle(input string tag, input state_t s,
                            input logic [3:0] o, input logic z);
    logic [3:0]  expState;
    logic [18:0] obsVec, expVec;
    expState = s;
    obsVec   = observedCtl();
    expVec   = expCtl(s, o, z);
    checkOutput({tag, "_state"}, {28'd0, state_dbg}, {28'd0, expState});
    checkOutput({tag, "_ctl"}, {13'd0, obsVec}, {13'd0, expVec});
    checkOutput({tag, "_busOneHot"},
                {31'd0, ($countones({ACC_bus, PC_bus, MDR_bus, Addr_bus}) <= 1)}, 32'd1);
  endtask

  // Holds reset over one edge; returns at the negedge of the first FETCH_ADDR cycle.
  task automatic applyReset();
    n_reset = 1'b0; step_mode = 1'b0; step_req = 1'b0; op = 4'd15; z_flag = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_reset = 1'b1;
    checkOutput("resetState", {28'd0, state_dbg}, 32'd0);
    checkOutput("resetPcBus", {31'd0, PC_bus}, 32'd1);
    checkOutput("resetHalted", {31'd0, halted}, 32'd0);
  endtask

  // Runs one instruction from a FETCH_ADDR negedge with stepping off and checks
  // every cycle against the phase list for that opcode.
  task automatic applyStimulus(input logic [3:0] o, input logic z);
    state_t seq[$];
    op = o; z_flag = z;
    seq = '{FETCH_ADDR, FETCH_MEM, FETCH_IR, DECODE};
    if (o == 4'd10) seq.push_back(HALT);
    else if (isMemAlu(o)) begin seq.push_back(OPER_MEM); seq.push_back(OPER_EXEC); end
    else if (o == 4'd1) begin seq.push_back(STORE_DATA); seq.push_back(STORE_MEM); end
    foreach (seq[i]) begin
      if (i > 0) @(negedge clock);
      checkCycle($sformatf("op%0d_c%0d", o, i), seq[i], o, z);
    end
    @(negedge clock);
  endtask

  // Cycles from this FETCH_ADDR until the next one, bounded.
  task automatic measurePeriod(input logic [3:0] o, input logic z, input int expected);
    int n;
    op = o; z_flag = z; n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (state_dbg != 4'd0 && n < 20);
    checkOutput($sformatf("period_op%0d", o), n, expected);
  endtask

  // Stepping: drives a step_req pattern one value per cycle and counts how
  // many instructions start (FETCH_ADDR cycles seen).
  task automatic stepRun(input string tag, input logic req[$], input int expFetches);
    int fetches;
    fetches = 0;
    foreach (req[i]) begin
      step_req = req[i];
      @(negedge clock);
      if (state_dbg == 4'd0) fetches++;
    end
    checkOutput({tag, "_fetches"}, fetches, expFetches);
    checkOutput({tag, "_parked"}, {28'd0, state_dbg}, 32'd8);
  endtask

  initial begin
    logic req[$];
    $display("[TB] cpu_sequencer bench starting");

    // LOAD, SUB, STORE, BEQ taken / not taken
    applyReset();
    applyStimulus(4'd0, 1'b0);
    applyStimulus(4'd3, 1'b0);
    measurePeriod(4'd3, 1'b1, 6);
    applyStimulus(4'd1, 1'b0);
    applyStimulus(4'd7, 1'b1);
    measurePeriod(4'd7, 1'b1, 4);
    applyStimulus(4'd7, 1'b0);
    applyStimulus(4'd8, 1'b0);
    applyStimulus(4'd12, 1'b1);

    // Random instruction stream (HALT excluded, it is covered below)
    for (int k = 0; k < 60; k++) begin
      logic [3:0] o;
      o = 4'($urandom_range(0, 15));
      if (o == 4'd10) o = 4'd9;
      applyStimulus(o, 1'($urandom_range(0, 1)));
    end

    // Stepping: a held request releases nothing more once parked
    applyReset();
    step_mode = 1'b1; op = 4'd9; z_flag = 1'b0;
    req = {};
    for (int i = 0; i < 20; i++) req.push_back(1'b1);
    stepRun("stepHeld", req, 0);
    req = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    stepRun("stepSecond", req, 1);
    // Edge during FETCH_MEM of the released instruction is dropped
    req = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    stepRun("stepDiscard", req, 1);
    // Falling step_mode lets the parked sequencer run freely again
    step_mode = 1'b0; step_req = 1'b0;
    @(negedge clock);
    checkOutput("stepModeOff", {28'd0, state_dbg}, 32'd0);
    applyStimulus(4'd2, 1'b0);

    // Reset aborts a write in STORE_MEM
    applyReset();
    op = 4'd1;
    repeat (5) @(negedge clock);
    checkCycle("storeMem", STORE_MEM, 4'd1, 1'b0);
    n_reset = 1'b0;
    @(negedge clock);
    n_reset = 1'b1;
    checkOutput("abortState", {28'd0, state_dbg}, 32'd0);
    checkOutput("abortNoWrite", {30'd0, CS, R_NW}, 32'd1);

    // HALT holds through step_req activity, only reset leaves
    applyStimulus(4'd10, 1'b0);
    for (int i = 0; i < 50; i++) begin
      step_req = 1'($urandom_range(0, 1));
      if (i % 10 == 0) step_mode = ~step_mode;
      @(negedge clock);
      checkOutput($sformatf("halt_c%0d", i), {27'd0, state_dbg, halted}, {27'd0, 4'd9, 1'b1});
    end
    step_mode = 1'b0; step_req = 1'b0;
    n_reset = 1'b0;
    @(negedge clock);
    n_reset = 1'b1;
    checkOutput("haltResetState", {28'd0, state_dbg}, 32'd0);
    checkOutput("haltResetHalted", {31'd0, halted}, 32'd0);
    checkOutput("haltResetPcBus", {31'd0, PC_bus}, 32'd1);
    applyStimulus(4'd4, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
